pic_alu_seq: RTL and testbench
==============================

PIC_ALU_SEQ -- requirements
Module: pic_alu_seq

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter MUL_EN, default 1, enables the multi-cycle MUL op; when 0, MUL SHALL be treated as an unknown op.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 in_valid  in  1  request valid; in_ready  out  1  block can accept.
REQ-006 op  in  5  operation code, enumerated in the shared package.
REQ-007 a  in  DATA_W  W-register operand; b  in  DATA_W  file-register operand.
REQ-008 bit_sel  in  clog2(DATA_W)  bit index for BCF/BSF/BTFSC/BTFSS.
REQ-009 out_valid  out  1  result valid; out_ready  in  1  consumer accepts.
REQ-010 result  out  DATA_W  primary result (MUL low half); result_hi  out  DATA_W  MUL high half, 0 for other ops.
REQ-011 test  out  1  skip condition for BTFSC/BTFSS, 0 for other ops.
REQ-012 status_z, status_dc, status_c  out  1 each  registered status flags.
REQ-013 busy  out  1  MUL iteration in progress.

Function
REQ-014 Accept SHALL occur on in_valid && in_ready; in_ready = !busy && (!out_valid || out_ready).
REQ-015 Single-cycle ops SHALL present result with out_valid asserted on the edge following accept (latency 1).
REQ-016 result, result_hi, test SHALL hold stable while out_valid && !out_ready.
REQ-017 out_valid SHALL clear on out_valid && out_ready unless a new result is registered on the same edge.
REQ-018 Ops: ADD a+b; SUB b-a; AND; IOR; XOR; COM ~b; INC b+1; DEC b-1; MOV b; MOVW a; CLR 0; RLF {b,C}; RRF {C,b}; SWAP half-word swap of b; BCF/BSF clear/set b[bit_sel]; BTFSC test=~b[bit_sel]; BTFSS test=b[bit_sel]; MUL unsigned a*b.
REQ-019 All arithmetic SHALL wrap modulo 2^DATA_W; C = carry out of bit DATA_W-1, DC = carry out of bit 3.
REQ-020 SUB C and DC SHALL be inverted borrow (1 = no borrow), computed as b + ~a + 1.
REQ-021 RLF/RRF SHALL consume the registered status_c and update it with the bit shifted out, so back-to-back rotates chain correctly.
REQ-022 Z SHALL update for ADD, SUB, AND, IOR, XOR, COM, INC, DEC, MOV, CLR, MUL (Z = full 2*DATA_W product zero); C/DC SHALL update only for ADD/SUB; C also for RLF/RRF and MUL (C = result_hi nonzero).
REQ-023 Flags not updated by an op SHALL retain their previous value; flags commit on the same edge as result.
REQ-024 MUL FSM states IDLE -> MUL (DATA_W shift-add iterations, one per cycle) -> DONE; out_valid asserts exactly DATA_W+1 cycles after accept, independent of operand values.
REQ-025 busy SHALL be 1 in MUL state only; in_valid during busy SHALL be ignored (in_ready=0).
REQ-026 Unknown op SHALL return result=b, result_hi=0, test=0, flags unchanged, latency 1.

Reset
REQ-027 rst_n low SHALL immediately clear out_valid, busy, result, result_hi, test, status_z/dc/c, and force FSM to IDLE, aborting any MUL in progress.
REQ-028 in_ready SHALL read 1 in the first cycle after rst_n deasserts.

Structure
REQ-029 Op enumeration, flag-update mask table, and FSM state type SHALL live in shared package pic_alu_pkg.
REQ-030 The iterative multiplier SHALL be a sub-module pic_alu_mul (start, done, a, b, product).

Verification (DATA_W=8)
REQ-031 ADD a=0x0F b=0x01 -> result 0x10, DC=1, C=0, Z=0; ADD a=0x01 b=0xFF -> 0x00, Z=1, C=1, DC=1.
REQ-032 SUB b=0x05 a=0x05 -> 0x00, Z=1, C=1, DC=1; SUB b=0x00 a=0x01 -> 0xFF, C=0, DC=0, Z=0.
REQ-033 MUL a=0xFF b=0xFF -> result_hi 0xFE, result 0x01, C=1, out_valid exactly 9 cycles after accept, in_ready=0 throughout.
REQ-034 status_c=1, RLF b=0x80 then RLF b=0x00 back-to-back -> 0x01 with C=1, then 0x01 with C=0.
REQ-035 out_ready held low 3 cycles after an AND result -> result stable, in_ready=0; accept next request on the edge out_ready rises.
REQ-036 rst_n pulsed low 4 cycles into MUL -> out_valid=0, busy=0, flags=0 immediately; next ADD completes normally.

Source files
------------

// File: rtl/pic_alu_pkg.sv
// Shared definitions for the PIC-style sequential ALU.
// Contents: operation encoding, status-flag update mask table,
// multiply FSM state type.
package pic_alu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_IOR   = 5'd3,
        OP_XOR   = 5'd4,
        OP_COM   = 5'd5,
        OP_INC   = 5'd6,
        OP_DEC   = 5'd7,
        OP_MOV   = 5'd8,
        OP_MOVW  = 5'd9,
        OP_CLR   = 5'd10,
        OP_RLF   = 5'd11,
        OP_RRF   = 5'd12,
        OP_SWAP  = 5'd13,
        OP_BCF   = 5'd14,
        OP_BSF   = 5'd15,
        OP_BTFSC = 5'd16,
        OP_BTFSS = 5'd17,
        OP_MUL   = 5'd18
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic z;
        logic dc;
        logic c;
    } flag_mask_t;

    // Which status flags each operation is allowed to write.
    function automatic flag_mask_t flag_mask(input op_e op);
        flag_mask_t m;
        case (op)
            OP_ADD, OP_SUB:                   m = 3'b111;
            OP_AND, OP_IOR, OP_XOR, OP_COM,
            OP_INC, OP_DEC, OP_MOV, OP_CLR:   m = 3'b100;
            OP_RLF, OP_RRF:                   m = 3'b001;
            OP_MUL:                           m = 3'b101;
            default:                          m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pic_alu_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports: start (load operands, begin), a/b operands, done (one-cycle pulse
// after DATA_W iterations), product (full 2*DATA_W result, valid with done).
module pic_alu_mul #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    import pic_alu_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   mcand_r;
    logic [2*DATA_W-1:0] prod_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                run_r;
    logic                done_r;
    logic [DATA_W:0]     sum_s;

    // Add the multiplicand into the upper half when the current multiplier LSB is set.
    always_comb begin
        sum_s = {1'b0, prod_r[2*DATA_W-1:DATA_W]};
        if (prod_r[0]) begin
            sum_s = {1'b0, prod_r[2*DATA_W-1:DATA_W]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, prod_r[2*DATA_W-1:DATA_W]};
        end
    end

    // Operand load and shift-add iteration; the multiplier shifts out of the low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r <= {DATA_W{1'b0}};
            prod_r  <= {(2*DATA_W){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            run_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                mcand_r <= a;
                prod_r  <= {{DATA_W{1'b0}}, b};
                cnt_r   <= {CNT_W{1'b0}};
                run_r   <= 1'b1;
            end else if (run_r) begin
                prod_r <= {sum_s, prod_r[DATA_W-1:1]};
                cnt_r  <= cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(DATA_W - 1)) begin
                    run_r  <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign done    = done_r;
    assign product = prod_r;

endmodule

// File: rtl/pic_alu_seq.sv
// PIC-style ALU with valid/ready handshake and registered status flags.
// Single-cycle ops return one cycle after accept; MUL runs through an
// iterative multiplier and returns DATA_W+1 cycles after accept.
// Ports: in_valid/in_ready request handshake; op, a (W reg), b (file reg),
// bit_sel operands; out_valid/out_ready result handshake; result,
// result_hi (MUL high half), test (skip condition); status_z/dc/c flags;
// busy while the multiplier iterates.
module pic_alu_seq #(
    parameter int DATA_W = 8,
    parameter int MUL_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 op,
    input  logic [DATA_W-1:0]          a,
    input  logic [DATA_W-1:0]          b,
    input  logic [$clog2(DATA_W)-1:0]  bit_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          result,
    output logic [DATA_W-1:0]          result_hi,
    output logic                       test,
    output logic                       status_z,
    output logic                       status_dc,
    output logic                       status_c,
    output logic                       busy
);
    import pic_alu_pkg::*;

    localparam int H = DATA_W / 2;

    mul_state_e          state_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   result_r;
    logic [DATA_W-1:0]   result_hi_r;
    logic                test_r;
    logic                z_r;
    logic                dc_r;
    logic                c_r;

    op_e                 op_s;
    logic                mul_sel_s;
    logic                accept_s;
    logic                mul_start_s;
    logic                mul_done_s;
    logic [2*DATA_W-1:0] mul_prod_s;
    flag_mask_t          mask_s;
    flag_mask_t          mul_mask_s;
    logic [DATA_W:0]     add_s;
    logic [DATA_W:0]     sub_s;
    logic [4:0]          addn_s;
    logic [4:0]          subn_s;
    logic [DATA_W-1:0]   alu_res_s;
    logic                alu_test_s;
    logic                alu_c_s;
    logic                alu_dc_s;

    assign op_s        = op_e'(op);
    // With the multiplier disabled MUL falls through to the unknown-op path.
    assign mul_sel_s   = (op_s == OP_MUL) && (MUL_EN != 0);
    assign busy        = (state_r == ST_MUL);
    assign in_ready    = (state_r != ST_MUL) && (!out_valid_r || out_ready);
    assign accept_s    = in_valid && in_ready;
    assign mul_start_s = accept_s && mul_sel_s;
    assign mask_s      = (op_s == OP_MUL) ? flag_mask_t'(3'b000) : flag_mask(op_s);
    assign mul_mask_s  = flag_mask(OP_MUL);

    // SUB is b + ~a + 1 so C/DC come out as inverted borrow.
    assign add_s  = {1'b0, a} + {1'b0, b};
    assign sub_s  = {1'b0, b} + {1'b0, ~a} + {{DATA_W{1'b0}}, 1'b1};
    assign addn_s = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    assign subn_s = {1'b0, b[3:0]} + {1'b0, ~a[3:0]} + 5'd1;

    pic_alu_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Single-cycle datapath; rotates consume the registered carry.
    always_comb begin
        alu_res_s  = b;
        alu_test_s = 1'b0;
        alu_c_s    = c_r;
        alu_dc_s   = dc_r;
        case (op_s)
            OP_ADD: begin
                alu_res_s = add_s[DATA_W-1:0];
                alu_c_s   = add_s[DATA_W];
                alu_dc_s  = addn_s[4];
            end
            OP_SUB: begin
                alu_res_s = sub_s[DATA_W-1:0];
                alu_c_s   = sub_s[DATA_W];
                alu_dc_s  = subn_s[4];
            end
            OP_AND:   alu_res_s = a & b;
            OP_IOR:   alu_res_s = a | b;
            OP_XOR:   alu_res_s = a ^ b;
            OP_COM:   alu_res_s = ~b;
            OP_INC:   alu_res_s = b + DATA_W'(1);
            OP_DEC:   alu_res_s = b - DATA_W'(1);
            OP_MOV:   alu_res_s = b;
            OP_MOVW:  alu_res_s = a;
            OP_CLR:   alu_res_s = {DATA_W{1'b0}};
            OP_RLF: begin
                alu_res_s = {b[DATA_W-2:0], c_r};
                alu_c_s   = b[DATA_W-1];
            end
            OP_RRF: begin
                alu_res_s = {c_r, b[DATA_W-1:1]};
                alu_c_s   = b[0];
            end
            OP_SWAP:  alu_res_s = {b[H-1:0], b[DATA_W-1:H]};
            OP_BCF:   alu_res_s[bit_sel] = 1'b0;
            OP_BSF:   alu_res_s[bit_sel] = 1'b1;
            OP_BTFSC: alu_test_s = ~b[bit_sel];
            OP_BTFSS: alu_test_s = b[bit_sel];
            default:  alu_res_s = b;
        endcase
    end

    // Control FSM, result registers and flag commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {DATA_W{1'b0}};
            result_hi_r <= {DATA_W{1'b0}};
            test_r      <= 1'b0;
            z_r         <= 1'b0;
            dc_r        <= 1'b0;
            c_r         <= 1'b0;
        end else begin
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    state_r <= ST_IDLE;
                    if (accept_s) begin
                        if (mul_sel_s) begin
                            state_r <= ST_MUL;
                        end else begin
                            out_valid_r <= 1'b1;
                            result_r    <= alu_res_s;
                            result_hi_r <= {DATA_W{1'b0}};
                            test_r      <= alu_test_s;
                            if (mask_s.z)  z_r  <= (alu_res_s == {DATA_W{1'b0}});
                            if (mask_s.dc) dc_r <= alu_dc_s;
                            if (mask_s.c)  c_r  <= alu_c_s;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= mul_prod_s[DATA_W-1:0];
                        result_hi_r <= mul_prod_s[2*DATA_W-1:DATA_W];
                        test_r      <= 1'b0;
                        if (mul_mask_s.z) z_r <= (mul_prod_s == {(2*DATA_W){1'b0}});
                        if (mul_mask_s.c) c_r <= (mul_prod_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign test      = test_r;
    assign status_z  = z_r;
    assign status_dc = dc_r;
    assign status_c  = c_r;

endmodule

// File: tb/tb_pic_alu_seq.sv
// Scoreboard bench for pic_alu_seq (DATA_W=8): directed vectors push their
// hand-computed responses; a monitor pops and compares on each output handshake.
module tb_pic_alu_seq;
    import pic_alu_pkg::*;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic       t;
        logic       z;
        logic       dc;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] op = 5'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic [2:0] bit_sel = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       test;
    logic       status_z;
    logic       status_dc;
    logic       status_c;
    logic       busy;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    pic_alu_seq #(.DATA_W(8), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .bit_sel   (bit_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .test      (test),
        .status_z  (status_z),
        .status_dc (status_dc),
        .status_c  (status_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] r, input logic [7:0] h,
                                input logic t, input logic z, input logic dc, input logic c);
        exp_t e;
        e.res = r; e.hi = h; e.t = t; e.z = z; e.dc = dc; e.c = c;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [4:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] sel, input exp_t e, input bit push, output int waited);
        waited = 0;
        op = o; a = av; b = bv; bit_sel = sel; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op %0d not accepted within 50 cycles", o);
        end else begin
            @(posedge clk);
            if (push) exp_q.push_back(e);
        end
        #1 in_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare the popped expectation at every output handshake.
    initial begin
        exp_t e;
        logic [19:0] got;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                got = {result, result_hi, test, status_z, status_dc, status_c};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected: got %05h with no expectation", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got res=%02h hi=%02h t=%0b z=%0b dc=%0b c=%0b expected res=%02h hi=%02h t=%0b z=%0b dc=%0b c=%0b",
                                 result, result_hi, test, status_z, status_dc, status_c,
                                 e.res, e.hi, e.t, e.z, e.dc, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cyc;
        bit ok;

        // Reset state, observed while reset is held and in the first cycle after.
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", {16'd0, result_hi, result}, 32'd0);
        chk("rst_flags", {29'd0, status_z, status_dc, status_c}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Arithmetic and logic, flag values tracked by hand across the sequence.
        send(OP_ADD,  8'h0F, 8'h01, 3'd0, mk(8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, w);
        send(OP_ADD,  8'h01, 8'hFF, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1), 1'b1, w);
        send(OP_SUB,  8'h05, 8'h05, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1), 1'b1, w);
        send(OP_SUB,  8'h01, 8'h00, 3'd0, mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
        send(OP_AND,  8'hF0, 8'h3C, 3'd0, mk(8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
        send(OP_IOR,  8'h0F, 8'h30, 3'd0, mk(8'h3F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
        send(OP_XOR,  8'hAA, 8'hAA, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_COM,  8'h00, 8'h0F, 3'd0, mk(8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
        send(OP_INC,  8'h00, 8'hFF, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_DEC,  8'h00, 8'h00, 3'd0, mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
        send(OP_MOVW, 8'h00, 8'h55, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
        send(OP_MOV,  8'h11, 8'h00, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_IOR,  8'h01, 8'h00, 3'd0, mk(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
        send(OP_CLR,  8'h12, 8'h34, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_ADD,  8'h80, 8'h80, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1, w);

        // Back-to-back rotates chaining through the registered carry.
        send(OP_RLF,  8'h00, 8'h80, 3'd0, mk(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1, w);
        send(OP_RLF,  8'h00, 8'h00, 3'd0, mk(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_RRF,  8'h00, 8'h01, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1, w);
        send(OP_RRF,  8'h00, 8'h00, 3'd0, mk(8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);

        // Bit ops, swap and an unknown opcode.
        send(OP_SWAP,  8'h00, 8'hA5, 3'd0, mk(8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_BCF,   8'h00, 8'hFF, 3'd3, mk(8'hF7, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_BSF,   8'h00, 8'h00, 3'd7, mk(8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_BTFSC, 8'h00, 8'h08, 3'd3, mk(8'h08, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_BTFSS, 8'h00, 8'h08, 3'd3, mk(8'h08, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_BTFSC, 8'h00, 8'h00, 3'd0, mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_BTFSS, 8'h00, 8'hFE, 3'd0, mk(8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(5'd31,    8'h12, 8'h34, 3'd0, mk(8'h34, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);

        // MUL 0xFF*0xFF with latency and in_ready/busy checks.
        send(OP_MUL, 8'hFF, 8'hFF, 3'd0, mk(8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, w);
        cyc = 0; ok = 1'b1;
        while (!out_valid && cyc < 20) begin
            if (in_ready || !busy) ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk("mul_latency", cyc, 32'd9);
        chk("mul_in_ready_low_busy_high", {31'd0, ok}, 32'd1);
        send(OP_MUL, 8'h00, 8'h37, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
        send(OP_MUL, 8'h03, 8'h05, 3'd0, mk(8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);

        // Output stall: result held, in_ready low, next request accepted as out_ready rises.
        send(OP_AND, 8'hFF, 8'h0F, 3'd0, mk(8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_result", {23'd0, out_valid, result}, {23'd0, 1'b1, 8'h0F});
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(OP_ADD, 8'hFF, 8'h02, 3'd0, mk(8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1, w);
        chk("stall_release_accept_wait", w, 32'd0);
        chk("stall_release_next_result", {23'd0, out_valid, result}, {23'd0, 1'b1, 8'h01});

        // Reset pulse in the middle of a MUL.
        send(OP_MUL, 8'hFF, 8'hFF, 3'd0, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, w);
        repeat (4) @(posedge clk);
        #1;
        chk("mul_busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid_busy", {30'd0, out_valid, busy}, 32'd0);
        chk("abort_flags", {29'd0, status_z, status_dc, status_c}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        send(OP_ADD, 8'h0F, 8'h01, 3'd0, mk(8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, w);

        // Drain the scoreboard with a bounded wait.
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 30) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
